// File: rtl/imc_pkg.sv
// ----------------------------------------------------------------------------
// imc_pkg
// Shared types and defaults for the in-memory-compute access sequencer.
//   op_t    : array command opcodes as encoded on cmd_op
//   state_t : sequencer FSM states
//   imc_max : constant-friendly integer max, used to size the phase counter
//   op_is_dual : true for the ops that activate two read rows
// ----------------------------------------------------------------------------
package imc_pkg;

    localparam int IMC_ADDR_W     = 7;
    localparam int IMC_DATA_W     = 128;
    localparam int IMC_PRE_CYCLES = 1;
    localparam int IMC_WL_CYCLES  = 2;

    typedef enum logic [1:0] {
        OP_READ  = 2'd0,
        OP_DREAD = 2'd1,
        OP_WRITE = 2'd2,
        OP_CWB   = 2'd3
    } op_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_RD   = 3'd2,
        ST_WR   = 3'd3,
        ST_RESP = 3'd4
    } state_t;

    function automatic int imc_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic op_is_dual(input op_t op);
        return (op == OP_DREAD) || (op == OP_CWB);
    endfunction

endpackage

// File: rtl/imc_phase_timer.sv
// ----------------------------------------------------------------------------
// imc_phase_timer
// Loadable down-counter that times each sequencer phase. Loading N makes the
// phase last N+1 cycles; the count saturates at zero.
//   clk, rst     : clock, synchronous active-high reset
//   i_load       : load i_load_val this cycle (phase entry)
//   i_load_val   : phase length minus one
//   o_last       : current cycle is the last of the phase
//   o_next_last  : the following cycle will be the last of the phase
// ----------------------------------------------------------------------------
module imc_phase_timer #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_last,
    output logic             o_next_last
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;

    // Next count: load on phase entry, otherwise count down to zero and hold.
    always_comb begin
        w_cnt_next = r_cnt;
        if (i_load) begin
            w_cnt_next = i_load_val;
        end else if (r_cnt != {CNT_W{1'b0}}) begin
            w_cnt_next = r_cnt - CNT_W'(1);
        end else begin
            w_cnt_next = r_cnt;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= {CNT_W{1'b0}};
        end else begin
            r_cnt <= w_cnt_next;
        end
    end

    assign o_last      = (r_cnt == {CNT_W{1'b0}});
    assign o_next_last = (w_cnt_next == {CNT_W{1'b0}});

endmodule

// File: rtl/imc_access_sequencer.sv
// ----------------------------------------------------------------------------
// imc_access_sequencer
// Initiator side of the SRAM wordline decoder interface. Accepts one array
// command at a time and steps precharge -> wordline read and/or write ->
// response, keeping read and write enables mutually exclusive.
//   cmd_*                : command request (valid/ready), op, rows, write data
//   read_address1/2, read_enable1/2, write_address, write_enable : decoder
//   precharge, sa_en     : bitline precharge and sense-amp enable
//   sa_data1/2           : sense lines in, bl_wdata : write-driver data out
//   rsp_*                : response (valid/ready) with captured data
// All outputs are registered and decoded from the next FSM state, so every
// output reflects the phase the array is in during that cycle.
// ----------------------------------------------------------------------------
module imc_access_sequencer
    import imc_pkg::*;
#(
    parameter int ADDR_W     = IMC_ADDR_W,
    parameter int DATA_W     = IMC_DATA_W,
    parameter int PRE_CYCLES = IMC_PRE_CYCLES,
    parameter int WL_CYCLES  = IMC_WL_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr_a,
    input  logic [ADDR_W-1:0] cmd_addr_b,
    input  logic [ADDR_W-1:0] cmd_addr_d,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic [ADDR_W-1:0] read_address1,
    output logic [ADDR_W-1:0] read_address2,
    output logic              read_enable1,
    output logic              read_enable2,
    output logic [ADDR_W-1:0] write_address,
    output logic              write_enable,
    output logic              precharge,
    output logic              sa_en,
    input  logic [DATA_W-1:0] sa_data1,
    input  logic [DATA_W-1:0] sa_data2,
    output logic [DATA_W-1:0] bl_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data1,
    output logic [DATA_W-1:0] rsp_data2
);

    localparam int CNT_W = $clog2(imc_max(PRE_CYCLES, WL_CYCLES) + 1);

    // FSM and latched command
    state_t            r_state;
    state_t            w_state_next;
    op_t               r_op;
    logic [ADDR_W-1:0] r_addr_a;
    logic [ADDR_W-1:0] r_addr_b;
    logic [ADDR_W-1:0] r_addr_d;
    logic [DATA_W-1:0] r_wdata;
    logic              r_wb_pending;
    logic [DATA_W-1:0] r_cap1;
    logic [DATA_W-1:0] r_cap2;

    // Registered outputs
    logic              r_cmd_ready;
    logic [ADDR_W-1:0] r_read_address1;
    logic [ADDR_W-1:0] r_read_address2;
    logic              r_read_enable1;
    logic              r_read_enable2;
    logic [ADDR_W-1:0] r_write_address;
    logic              r_write_enable;
    logic              r_precharge;
    logic              r_sa_en;
    logic [DATA_W-1:0] r_bl_wdata;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_data1;
    logic [DATA_W-1:0] r_rsp_data2;

    // Combinational next values
    logic              w_accept;
    logic              w_dual_rd;
    logic              w_capture;
    logic              w_load;
    logic [CNT_W-1:0]  w_load_val;
    logic              w_last;
    logic              w_next_last;
    logic [DATA_W-1:0] w_cap1_next;
    logic [DATA_W-1:0] w_cap2_next;

    assign w_accept  = (r_state == ST_IDLE) && cmd_valid && r_cmd_ready;
    // A dual op on a single row degenerates to one wordline; the second
    // sense value is then a copy of the first.
    assign w_dual_rd = op_is_dual(r_op) && (r_addr_a != r_addr_b);
    assign w_capture = (r_state == ST_RD) && w_last;

    // Phase counter is reloaded on every state change.
    assign w_load     = (w_state_next != r_state);
    assign w_load_val = ((w_state_next == ST_RD) || (w_state_next == ST_WR)) ?
                        CNT_W'(WL_CYCLES - 1) : CNT_W'(PRE_CYCLES - 1);

    imc_phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_load),
        .i_load_val  (w_load_val),
        .o_last      (w_last),
        .o_next_last (w_next_last)
    );

    // Next-state decode.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_state_next = ST_PRE;
                else          w_state_next = ST_IDLE;
            end
            ST_PRE: begin
                if (w_last) begin
                    w_state_next = ((r_op == OP_WRITE) || r_wb_pending) ? ST_WR : ST_RD;
                end else begin
                    w_state_next = ST_PRE;
                end
            end
            ST_RD: begin
                if (w_last) w_state_next = (r_op == OP_CWB) ? ST_PRE : ST_RESP;
                else        w_state_next = ST_RD;
            end
            ST_WR: begin
                if (w_last) w_state_next = ST_RESP;
                else        w_state_next = ST_WR;
            end
            ST_RESP: begin
                if (r_rsp_valid && rsp_ready) w_state_next = ST_IDLE;
                else                          w_state_next = ST_RESP;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Sense data captured at the edge that ends the last wordline cycle.
    always_comb begin
        w_cap1_next = r_cap1;
        w_cap2_next = r_cap2;
        if (w_capture) begin
            w_cap1_next = sa_data1;
            if (op_is_dual(r_op)) begin
                w_cap2_next = w_dual_rd ? sa_data2 : sa_data1;
            end else begin
                w_cap2_next = {DATA_W{1'b0}};
            end
        end else begin
            w_cap1_next = r_cap1;
            w_cap2_next = r_cap2;
        end
    end

    // State, command latch, write-back flag and capture registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_op         <= OP_READ;
            r_addr_a     <= {ADDR_W{1'b0}};
            r_addr_b     <= {ADDR_W{1'b0}};
            r_addr_d     <= {ADDR_W{1'b0}};
            r_wdata      <= {DATA_W{1'b0}};
            r_wb_pending <= 1'b0;
            r_cap1       <= {DATA_W{1'b0}};
            r_cap2       <= {DATA_W{1'b0}};
        end else begin
            r_state <= w_state_next;
            r_cap1  <= w_cap1_next;
            r_cap2  <= w_cap2_next;
            if (w_accept) begin
                r_op     <= op_t'(cmd_op);
                r_addr_a <= cmd_addr_a;
                r_addr_b <= cmd_addr_b;
                r_addr_d <= cmd_addr_d;
                r_wdata  <= cmd_wdata;
            end
            if (w_capture && (r_op == OP_CWB)) begin
                r_wb_pending <= 1'b1;
            end else if ((r_state == ST_WR) && w_last) begin
                r_wb_pending <= 1'b0;
            end
        end
    end

    // Output registers, decoded from the state the array enters next.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmd_ready     <= 1'b0;
            r_precharge     <= 1'b0;
            r_read_enable1  <= 1'b0;
            r_read_enable2  <= 1'b0;
            r_read_address1 <= {ADDR_W{1'b0}};
            r_read_address2 <= {ADDR_W{1'b0}};
            r_write_enable  <= 1'b0;
            r_write_address <= {ADDR_W{1'b0}};
            r_bl_wdata      <= {DATA_W{1'b0}};
            r_sa_en         <= 1'b0;
            r_rsp_valid     <= 1'b0;
            r_rsp_data1     <= {DATA_W{1'b0}};
            r_rsp_data2     <= {DATA_W{1'b0}};
        end else begin
            r_cmd_ready     <= (w_state_next == ST_IDLE);
            r_precharge     <= (w_state_next == ST_PRE);
            r_read_enable1  <= (w_state_next == ST_RD);
            r_read_enable2  <= (w_state_next == ST_RD) && w_dual_rd;
            r_read_address1 <= (w_state_next == ST_RD) ? r_addr_a : {ADDR_W{1'b0}};
            r_read_address2 <= ((w_state_next == ST_RD) && w_dual_rd) ? r_addr_b : {ADDR_W{1'b0}};
            r_write_enable  <= (w_state_next == ST_WR);
            r_write_address <= (w_state_next == ST_WR) ? r_addr_d : {ADDR_W{1'b0}};
            r_bl_wdata      <= (w_state_next != ST_WR) ? {DATA_W{1'b0}} :
                               (r_op == OP_WRITE)      ? r_wdata : w_cap1_next;
            r_sa_en         <= (w_state_next == ST_RD) && w_next_last;
            r_rsp_valid     <= (w_state_next == ST_RESP);
            r_rsp_data1     <= (w_state_next != ST_RESP) ? {DATA_W{1'b0}} :
                               (r_op == OP_WRITE)        ? r_wdata : w_cap1_next;
            r_rsp_data2     <= ((w_state_next != ST_RESP) || (r_op == OP_WRITE)) ?
                               {DATA_W{1'b0}} : w_cap2_next;
        end
    end

    assign cmd_ready     = r_cmd_ready;
    assign precharge     = r_precharge;
    assign read_enable1  = r_read_enable1;
    assign read_enable2  = r_read_enable2;
    assign read_address1 = r_read_address1;
    assign read_address2 = r_read_address2;
    assign write_enable  = r_write_enable;
    assign write_address = r_write_address;
    assign bl_wdata      = r_bl_wdata;
    assign sa_en         = r_sa_en;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_data1     = r_rsp_data1;
    assign rsp_data2     = r_rsp_data2;

endmodule

// File: tb/tb_imc_access_sequencer.sv
// ----------------------------------------------------------------------------
// tb_imc_access_sequencer
// Directed bench for imc_access_sequencer with default parameters.
// Inputs are driven just after the falling edge, outputs sampled on the
// falling edge. Cycle 0 is the cycle in which the command handshake occurs.
// ctl packs {precharge, re1, re2, we, sa_en, rsp_valid, cmd_ready}.
// ----------------------------------------------------------------------------
module tb_imc_access_sequencer;
    import imc_pkg::*;

    localparam int AW = 7;
    localparam int DW = 128;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = 2'd0;
    logic [AW-1:0] cmd_addr_a = '0, cmd_addr_b = '0, cmd_addr_d = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic [AW-1:0] read_address1, read_address2, write_address;
    logic          read_enable1, read_enable2, write_enable, precharge, sa_en;
    logic [DW-1:0] sa_data1 = '0, sa_data2 = '0;
    logic [DW-1:0] bl_wdata;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [DW-1:0] rsp_data1, rsp_data2;

    int total = 0;
    int bad   = 0;

    logic [6:0]   ctl;
    logic [411:0] all_out;
    logic [411:0] exp_idle;

    assign ctl     = {precharge, read_enable1, read_enable2, write_enable, sa_en, rsp_valid, cmd_ready};
    assign all_out = {cmd_ready, read_enable1, read_enable2, write_enable, precharge, sa_en, rsp_valid,
                      read_address1, read_address2, write_address, bl_wdata, rsp_data1, rsp_data2};

    imc_access_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_addr_a    (cmd_addr_a),
        .cmd_addr_b    (cmd_addr_b),
        .cmd_addr_d    (cmd_addr_d),
        .cmd_wdata     (cmd_wdata),
        .read_address1 (read_address1),
        .read_address2 (read_address2),
        .read_enable1  (read_enable1),
        .read_enable2  (read_enable2),
        .write_address (write_address),
        .write_enable  (write_enable),
        .precharge     (precharge),
        .sa_en         (sa_en),
        .sa_data1      (sa_data1),
        .sa_data2      (sa_data2),
        .bl_wdata      (bl_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data1     (rsp_data1),
        .rsp_data2     (rsp_data2)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Present a command and wait (bounded) for the handshake edge.
    // Returns at the falling edge of cycle 1.
    task automatic send_cmd(input logic [1:0] op, input logic [AW-1:0] a, input logic [AW-1:0] b,
                            input logic [AW-1:0] d, input logic [DW-1:0] wd);
        int n;
        n = 0;
        cmd_op = op; cmd_addr_a = a; cmd_addr_b = b; cmd_addr_d = d; cmd_wdata = wd;
        cmd_valid = 1'b1;
        while (cmd_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= 20) begin
            bad++;
            $display("FAIL send_cmd_timeout: cmd_ready=%b required=1", cmd_ready);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        exp_idle = '0;
        exp_idle[411] = 1'b1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_first_ready: got %b want 1", cmd_ready); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total++;
            if (all_out !== '0) begin bad++; $display("FAIL reset_outputs_zero: got %h want 0", all_out); end
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (all_out !== exp_idle) begin bad++; $display("FAIL reset_release_idle: got %h want %h", all_out, exp_idle); end
    endtask

    task automatic test_read();
        logic [6:0] tbl [5];
        logic [DW-1:0] d1;
        tbl = '{7'b1000000, 7'b0100000, 7'b0100100, 7'b0000010, 7'b0000001};
        d1 = {16{8'hA5}};
        sa_data1 = d1; sa_data2 = {16{8'h3C}}; rsp_ready = 1'b1;
        send_cmd(2'd0, 7'd5, 7'd0, 7'd0, '0);
        for (int i = 1; i <= 5; i++) begin
            if (i > 1) @(negedge clk);
            total++;
            if (ctl !== tbl[i-1]) begin bad++; $display("FAIL read_ctl_c%0d: got %b want %b", i, ctl, tbl[i-1]); end
            if (i == 2 || i == 3) begin
                total++;
                if (read_address1 !== 7'd5) begin bad++; $display("FAIL read_addr1_c%0d: got %0d want 5", i, read_address1); end
            end
        end
        // data checked at cycle 4 is gone by cycle 5; re-run the response check via a second read
        send_cmd(2'd0, 7'd5, 7'd0, 7'd0, '0);
        repeat (3) @(negedge clk);
        total++;
        if (rsp_data1 !== d1) begin bad++; $display("FAIL read_rsp_data1: got %h want %h", rsp_data1, d1); end
        total++;
        if (rsp_data2 !== '0) begin bad++; $display("FAIL read_rsp_data2: got %h want 0", rsp_data2); end
        @(negedge clk);
    endtask

    task automatic test_dread();
        logic [6:0] tbl2 [5];
        logic [6:0] tbl1 [5];
        logic [DW-1:0] d1, d2;
        tbl2 = '{7'b1000000, 7'b0110000, 7'b0110100, 7'b0000010, 7'b0000001};
        tbl1 = '{7'b1000000, 7'b0100000, 7'b0100100, 7'b0000010, 7'b0000001};
        d1 = {16{8'h0F}}; d2 = {16{8'hF0}};
        sa_data1 = d1; sa_data2 = d2;
        send_cmd(2'd1, 7'd3, 7'd127, 7'd0, '0);
        for (int i = 1; i <= 4; i++) begin
            if (i > 1) @(negedge clk);
            total++;
            if (ctl !== tbl2[i-1]) begin bad++; $display("FAIL dread_ctl_c%0d: got %b want %b", i, ctl, tbl2[i-1]); end
            if (i == 2) begin
                total++;
                if ({read_address1, read_address2} !== {7'd3, 7'd127}) begin
                    bad++; $display("FAIL dread_addrs: got %0d/%0d want 3/127", read_address1, read_address2);
                end
            end
        end
        total++;
        if ({rsp_data1, rsp_data2} !== {d1, d2}) begin
            bad++; $display("FAIL dread_rsp: got %h/%h want %h/%h", rsp_data1, rsp_data2, d1, d2);
        end
        @(negedge clk);
        send_cmd(2'd1, 7'd9, 7'd9, 7'd0, '0);
        for (int i = 1; i <= 4; i++) begin
            if (i > 1) @(negedge clk);
            total++;
            if (ctl !== tbl1[i-1]) begin bad++; $display("FAIL dread_same_ctl_c%0d: got %b want %b", i, ctl, tbl1[i-1]); end
        end
        total++;
        if ({rsp_data1, rsp_data2} !== {d1, d1}) begin
            bad++; $display("FAIL dread_same_rsp: got %h/%h want %h/%h", rsp_data1, rsp_data2, d1, d1);
        end
        @(negedge clk);
    endtask

    task automatic test_cwb();
        logic [6:0] tbl [8];
        logic [DW-1:0] d1, d2;
        tbl = '{7'b0000000, 7'b1000000, 7'b0110000, 7'b0110100, 7'b1000000,
                7'b0001000, 7'b0001000, 7'b0000010};
        d1 = {16{8'h5A}}; d2 = {16{8'hC3}};
        sa_data1 = d1; sa_data2 = d2;
        send_cmd(2'd3, 7'd1, 7'd2, 7'd0, {DW{1'b1}});
        for (int i = 1; i <= 7; i++) begin
            if (i > 1) @(negedge clk);
            // sense lines change after capture; write-back must use captured data
            if (i == 4) begin sa_data1 = {16{8'h11}}; sa_data2 = {16{8'h22}}; end
            total++;
            if (ctl !== tbl[i]) begin bad++; $display("FAIL cwb_ctl_c%0d: got %b want %b", i, ctl, tbl[i]); end
            if (i == 2) begin
                total++;
                if ({read_address1, read_address2} !== {7'd1, 7'd2}) begin
                    bad++; $display("FAIL cwb_raddrs: got %0d/%0d want 1/2", read_address1, read_address2);
                end
            end
            if (i == 5 || i == 6) begin
                total++;
                if ({write_address, bl_wdata} !== {7'd0, d1}) begin
                    bad++; $display("FAIL cwb_write_c%0d: got %0d/%h want 0/%h", i, write_address, bl_wdata, d1);
                end
            end
        end
        total++;
        if ({rsp_data1, rsp_data2} !== {d1, d2}) begin
            bad++; $display("FAIL cwb_rsp: got %h/%h want %h/%h", rsp_data1, rsp_data2, d1, d2);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [6:0] tbl [4];
        logic [DW-1:0] wd, d1;
        tbl = '{7'b1000000, 7'b0001000, 7'b0001000, 7'b0000010};
        wd = {4{32'hDEADBEEF}};
        d1 = {8{16'h9182}};
        sa_data1 = d1; sa_data2 = {DW{1'b1}};
        rsp_ready = 1'b0;
        send_cmd(2'd2, 7'd0, 7'd0, 7'd127, wd);
        for (int i = 1; i <= 4; i++) begin
            if (i > 1) @(negedge clk);
            total++;
            if (ctl !== tbl[i-1]) begin bad++; $display("FAIL wr_ctl_c%0d: got %b want %b", i, ctl, tbl[i-1]); end
            if (i == 2) begin
                total++;
                if ({write_address, bl_wdata} !== {7'd127, wd}) begin
                    bad++; $display("FAIL wr_drive: got %0d/%h want 127/%h", write_address, bl_wdata, wd);
                end
            end
        end
        // queue a READ of row 127 while the response is stalled
        cmd_op = 2'd0; cmd_addr_a = 7'd127; cmd_addr_b = 7'd0; cmd_addr_d = 7'd0; cmd_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) @(negedge clk);
            total++;
            if ({rsp_valid, cmd_ready, rsp_data1, rsp_data2} !== {1'b1, 1'b0, wd, {DW{1'b0}}}) begin
                bad++; $display("FAIL bp_hold_%0d: got v=%b r=%b %h/%h want v=1 r=0 %h/0",
                                k, rsp_valid, cmd_ready, rsp_data1, rsp_data2, wd);
            end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        total++;
        if (ctl !== 7'b0000001) begin bad++; $display("FAIL bp_release: got %b want 0000001", ctl); end
        @(negedge clk);
        cmd_valid = 1'b0;
        total++;
        if (ctl !== 7'b1000000) begin bad++; $display("FAIL b2b_accept: got %b want 1000000", ctl); end
        @(negedge clk);
        total++;
        if ({read_enable1, read_address1} !== {1'b1, 7'd127}) begin
            bad++; $display("FAIL b2b_read_addr: got %b/%0d want 1/127", read_enable1, read_address1);
        end
        repeat (2) @(negedge clk);
        total++;
        if ({rsp_valid, rsp_data1} !== {1'b1, d1}) begin
            bad++; $display("FAIL b2b_rsp: got %b/%h want 1/%h", rsp_valid, rsp_data1, d1);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_write();
        logic seen;
        rsp_ready = 1'b1;
        send_cmd(2'd2, 7'd0, 7'd0, 7'd10, {4{32'h12345678}});
        @(negedge clk);
        total++;
        if ({write_enable, write_address} !== {1'b1, 7'd10}) begin
            bad++; $display("FAIL rstwr_pre: got %b/%0d want 1/10", write_enable, write_address);
        end
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (all_out !== '0) begin bad++; $display("FAIL rstwr_zero: got %h want 0", all_out); end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (all_out !== exp_idle) begin bad++; $display("FAIL rstwr_idle: got %h want %h", all_out, exp_idle); end
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            seen = seen | rsp_valid;
        end
        total++;
        if (seen !== 1'b0) begin bad++; $display("FAIL rstwr_no_rsp: got rsp_valid=%b want 0", seen); end
    endtask

    initial begin
        test_reset();
        test_read();
        test_dread();
        test_cwb();
        test_back_to_back();
        test_reset_mid_write();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
